// File: rtl/scoreboard_pkg.sv
// Shared constants for the pipeline scoreboard: register-file indices,
// default latency-counter width and the VAR (wait-for-completion) encoding.
package scoreboard_pkg;

  localparam int FILE_INT  = 0;
  localparam int FILE_FP   = 1;
  localparam int DEF_LAT_W = 4;

  // All-ones of the counter width marks an entry waiting on a completion
  function automatic int unsigned var_enc(input int unsigned lat_w);
    return (32'd1 << lat_w) - 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_scoreboard_if.sv
// ID-stage decode, completion and pipeline-control bundle of the scoreboard.
// master = decoder/pipeline side, slave = scoreboard.
interface pipeline_scoreboard_if
  import scoreboard_pkg::*;
#(
  parameter int NFILE = 2,
  parameter int LAT_W = DEF_LAT_W
);
  localparam int FW = (NFILE > 1) ? $clog2(NFILE) : 1;

  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             rs1_use_id;
  logic             rs2_use_id;
  logic [FW-1:0]    rs1_file_id;
  logic [FW-1:0]    rs2_file_id;
  logic [4:0]       rd_id;
  logic [FW-1:0]    rd_file_id;
  logic             rd_wr_id;
  logic [LAT_W-1:0] issue_lat;
  logic             issue_var;
  logic             issue_valid;
  logic             mem_stall;
  logic             branchtrue;
  logic             cpl_valid;
  logic [4:0]       cpl_rd;
  logic [FW-1:0]    cpl_file;
  logic             pcwrite;
  logic             ifidwrite;
  logic             nop_insert;
  logic             if_flush;
  logic             sb_err;
  logic [31:0]      stall_cycles;

  modport master (
    output rs1_id, rs2_id, rs1_use_id, rs2_use_id, rs1_file_id, rs2_file_id,
           rd_id, rd_file_id, rd_wr_id, issue_lat, issue_var, issue_valid,
           mem_stall, branchtrue, cpl_valid, cpl_rd, cpl_file,
    input  pcwrite, ifidwrite, nop_insert, if_flush, sb_err, stall_cycles
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_use_id, rs2_use_id, rs1_file_id, rs2_file_id,
           rd_id, rd_file_id, rd_wr_id, issue_lat, issue_var, issue_valid,
           mem_stall, branchtrue, cpl_valid, cpl_rd, cpl_file,
    output pcwrite, ifidwrite, nop_insert, if_flush, sb_err, stall_cycles
  );

endinterface

// File: rtl/sb_entry.sv
// One scoreboard entry: latency countdown for a single architectural register.
// 0 = idle, 1..VAR-1 = fixed countdown, VAR = waiting for a completion.
module sb_entry
  import scoreboard_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ld_i,
  input  logic [LAT_W-1:0] ld_val_i,
  input  logic             dec_i,
  input  logic             cpl_i,
  output logic [LAT_W-1:0] cnt_o
);
  localparam logic [LAT_W-1:0] VAR_C = LAT_W'(var_enc(LAT_W));

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  // Next count: an issue load wins over completion and countdown
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (cpl_i && (cnt_q == VAR_C)) begin
      cnt_d = '0;
    end else if (dec_i && (cnt_q != '0) && (cnt_q != VAR_C)) begin
      cnt_d = cnt_q - LAT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_scoreboard.sv
// Multi-file register scoreboard driving ID-stage stall/bubble/flush controls.
// Optional hazard-stall performance counter: PIPELINE_SCOREBOARD_PERF_EN.
module pipeline_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NFILE = 2,
  parameter int NREG  = 32,
  parameter int LAT_W = DEF_LAT_W
) (
  input logic                   clk,
  input logic                   rstn,
  pipeline_scoreboard_if.slave  sb
);
  localparam int FW   = (NFILE > 1) ? $clog2(NFILE) : 1;
  localparam int NENT = NFILE * NREG;
  localparam logic [LAT_W-1:0] VAR_C = LAT_W'(var_enc(LAT_W));

  logic [LAT_W-1:0] cnt_s [NENT];
  logic [NENT-1:0]  busy_s;
  logic [NENT-1:0]  cpl_hit_s;
  logic [NENT-1:0]  cpl_err_s;
  logic             rs1_busy_s;
  logic             rs2_busy_s;
  logic             rd_busy_s;
  logic             hazard_s;
  logic             accept_s;
  logic             lat_err_s;
  logic [LAT_W-1:0] ld_val_s;
  logic             sb_err_q;
  logic             sb_err_d;

  // Busy lookup for a (file, reg) pair; out-of-range indices are never busy
  function automatic logic lookup(input logic [NENT-1:0] busy,
                                  input logic [FW-1:0] f, input logic [4:0] r);
    if ((int'(f) < NFILE) && (int'(r) < NREG)) return busy[int'(f) * NREG + int'(r)];
    else return 1'b0;
  endfunction

  assign rs1_busy_s = sb.rs1_use_id & lookup(busy_s, sb.rs1_file_id, sb.rs1_id);
  assign rs2_busy_s = sb.rs2_use_id & lookup(busy_s, sb.rs2_file_id, sb.rs2_id);
  assign rd_busy_s  = sb.rd_wr_id   & lookup(busy_s, sb.rd_file_id,  sb.rd_id);
  assign hazard_s   = rs1_busy_s | rs2_busy_s | rd_busy_s;

  assign accept_s = sb.issue_valid & ~hazard_s & ~sb.branchtrue & ~sb.mem_stall &
                    sb.rd_wr_id & (sb.issue_var | (sb.issue_lat != '0));

  // Load value; an all-ones fixed latency is a protocol error and clamps to VAR-1
  always_comb begin
    lat_err_s = 1'b0;
    if (sb.issue_var) begin
      ld_val_s = VAR_C;
    end else if (sb.issue_lat == VAR_C) begin
      ld_val_s  = VAR_C - LAT_W'(1'b1);
      lat_err_s = accept_s;
    end else begin
      ld_val_s = sb.issue_lat;
    end
  end

  for (genvar f = 0; f < NFILE; f++) begin : g_file
    for (genvar r = 0; r < NREG; r++) begin : g_reg
      localparam int IDX = f * NREG + r;
      assign cpl_hit_s[IDX] = sb.cpl_valid && (sb.cpl_file == FW'(f)) && (sb.cpl_rd == 5'(r));
      assign cpl_err_s[IDX] = cpl_hit_s[IDX] && (cnt_s[IDX] != VAR_C);
      assign busy_s[IDX]    = (cnt_s[IDX] != '0);
      if ((f == FILE_INT) && (r == 0)) begin : g_x0
        // Integer x0 is hardwired zero and never tracked
        sb_entry #(.LAT_W(LAT_W)) u_entry (
          .clk(clk), .rstn(rstn), .ld_i(1'b0), .ld_val_i('0),
          .dec_i(1'b0), .cpl_i(1'b0), .cnt_o(cnt_s[IDX])
        );
      end else begin : g_trk
        sb_entry #(.LAT_W(LAT_W)) u_entry (
          .clk(clk), .rstn(rstn),
          .ld_i(accept_s && (sb.rd_file_id == FW'(f)) && (sb.rd_id == 5'(r))),
          .ld_val_i(ld_val_s),
          .dec_i(~sb.mem_stall),
          .cpl_i(cpl_hit_s[IDX]),
          .cnt_o(cnt_s[IDX])
        );
      end
    end
  end

  assign sb_err_d = sb_err_q | (|cpl_err_s) | lat_err_s;

  // Sticky protocol-error flag, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sb_err_q <= 1'b0;
    else       sb_err_q <= sb_err_d;
  end

  // A taken branch overrides the stall: the ID instruction is wrong-path
  assign sb.if_flush   = sb.branchtrue;
  assign sb.nop_insert = hazard_s | sb.branchtrue;
  assign sb.pcwrite    = ~hazard_s | sb.branchtrue;
  assign sb.ifidwrite  = ~hazard_s | sb.branchtrue;
  assign sb.sb_err     = sb_err_q;

`ifdef PIPELINE_SCOREBOARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] stall_d;

  // Next stall count: real hazard stalls only, saturating
  always_comb begin
    stall_d = stall_q;
    if (hazard_s && !sb.branchtrue && !sb.mem_stall && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Hazard-stall performance counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_q <= 32'd0;
    else       stall_q <= stall_d;
  end

  assign sb.stall_cycles = stall_q;
`else
  assign sb.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed self-checking bench for pipeline_scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are checked before
// the next rising edge.
module tb_pipeline_scoreboard;
  logic clk;
  logic rstn;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef PIPELINE_SCOREBOARD_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd32;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  pipeline_scoreboard_if #(.NFILE(2), .LAT_W(4)) sb_if ();

  pipeline_scoreboard #(.NFILE(2), .NREG(32), .LAT_W(4)) dut (
    .clk(clk), .rstn(rstn), .sb(sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {pcwrite, ifidwrite, nop_insert, if_flush}
  function automatic logic [3:0] ctl();
    return {sb_if.pcwrite, sb_if.ifidwrite, sb_if.nop_insert, sb_if.if_flush};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.rs1_id = 5'd0; sb_if.rs2_id = 5'd0;
    sb_if.rs1_use_id = 1'b0; sb_if.rs2_use_id = 1'b0;
    sb_if.rs1_file_id = 1'b0; sb_if.rs2_file_id = 1'b0;
    sb_if.rd_id = 5'd0; sb_if.rd_file_id = 1'b0; sb_if.rd_wr_id = 1'b0;
    sb_if.issue_lat = 4'd0; sb_if.issue_var = 1'b0; sb_if.issue_valid = 1'b0;
    sb_if.mem_stall = 1'b0; sb_if.branchtrue = 1'b0;
    sb_if.cpl_valid = 1'b0; sb_if.cpl_rd = 5'd0; sb_if.cpl_file = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] r1, input logic f1, input logic u1,
                        input logic [4:0] r2, input logic f2, input logic u2,
                        input logic [4:0] rd, input logic rdf, input logic wr,
                        input logic [3:0] lat, input logic vr);
    sb_if.rs1_id = r1; sb_if.rs1_file_id = f1; sb_if.rs1_use_id = u1;
    sb_if.rs2_id = r2; sb_if.rs2_file_id = f2; sb_if.rs2_use_id = u2;
    sb_if.rd_id = rd; sb_if.rd_file_id = rdf; sb_if.rd_wr_id = wr;
    sb_if.issue_lat = lat; sb_if.issue_var = vr; sb_if.issue_valid = 1'b1;
  endtask

  // Issue a producer with no source operands; it must not stall
  task automatic issue(input string tag, input logic [4:0] rd, input logic rdf,
                       input logic [3:0] lat, input logic vr);
    set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, rd, rdf, 1'b1, lat, vr);
    #1;
    chk({tag, "_issue"}, 32'(ctl()), 32'h0000_000C);
    tick();
    idle();
  endtask

  // Hold a consumer in ID, count its stall cycles, then let it go
  task automatic dep(input string tag, input logic [4:0] r1, input logic f1, input logic u1,
                     input logic [4:0] r2, input logic f2, input logic u2, input int exp_n);
    int n;
    n = 0;
    set_id(r1, f1, u1, r2, f2, u2, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (sb_if.nop_insert !== 1'b1) break;
      chk({tag, "_stallctl"}, 32'(ctl()), 32'h0000_0002);
      n++;
      tick();
    end
    chk({tag, "_stalls"}, 32'(n), 32'(exp_n));
    chk({tag, "_release"}, 32'(ctl()), 32'h0000_000C);
    tick();
    idle();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    #2;
    chk("rst_ctl", 32'(ctl()), 32'h0000_000C);
    chk("rst_err", 32'(sb_if.sb_err), 32'd0);
    chk("rst_perf", sb_if.stall_cycles, 32'd0);
    #10;
    rstn = 1'b1;
    tick();

    // Load-use: lat 1 -> one bubble
    issue("lu", 5'd5, 1'b0, 4'd1, 1'b0);
    dep("lu", 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1);

    // FPU latency: integer x3 is independent of f3
    issue("fpu_a", 5'd3, 1'b1, 4'd4, 1'b0);
    dep("fpu_int", 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 0);
    repeat (4) tick();
    issue("fpu_b", 5'd3, 1'b1, 4'd4, 1'b0);
    dep("fpu_fp", 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 4);

    // Variable latency: completion 10 cycles after issue, no same-cycle bypass
    issue("var", 5'd7, 1'b0, 4'd0, 1'b1);
    set_id(5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("var_wait", 32'(ctl()), 32'h0000_0002);
      tick();
    end
    sb_if.cpl_valid = 1'b1; sb_if.cpl_rd = 5'd7; sb_if.cpl_file = 1'b0;
    #1;
    chk("var_cplcycle", 32'(ctl()), 32'h0000_0002);
    tick();
    sb_if.cpl_valid = 1'b0;
    #1;
    chk("var_release", 32'(ctl()), 32'h0000_000C);
    tick();
    idle();
    chk("var_noerr", 32'(sb_if.sb_err), 32'd0);

    // Memory freeze: countdown holds while mem_stall is high
    issue("frz", 5'd1, 1'b1, 4'd3, 1'b0);
    set_id(5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("frz_first", 32'(ctl()), 32'h0000_0002);
    tick();
    sb_if.mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("frz_hold", 32'(ctl()), 32'h0000_0002);
      tick();
    end
    sb_if.mem_stall = 1'b0;
    dep("frz", 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2);

    // Taken branch over a hazard: flush wins, nothing is loaded
    issue("br", 5'd10, 1'b0, 4'd2, 1'b0);
    set_id(5'd10, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd12, 1'b0, 1'b1, 4'd3, 1'b0);
    sb_if.branchtrue = 1'b1;
    #1;
    chk("br_ctl", 32'(ctl()), 32'h0000_000F);
    tick();
    idle();
    set_id(5'd12, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("br_noload", 32'(ctl()), 32'h0000_000C);
    tick();
    idle();

    // Integer x0 is never tracked
    issue("x0", 5'd0, 1'b0, 4'd3, 1'b0);
    dep("x0", 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 0);
    chk("x0_noerr", 32'(sb_if.sb_err), 32'd0);

    // All-ones fixed latency: error, clamps to 14
    issue("lat15", 5'd20, 1'b0, 4'd15, 1'b0);
    chk("lat15_err", 32'(sb_if.sb_err), 32'd1);
    dep("lat15", 5'd20, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 14);
    chk("perf_total", sb_if.stall_cycles, PERF_EXP);

    // Asynchronous reset mid-operation clears pending entries at once
    issue("mrst", 5'd21, 1'b0, 4'd5, 1'b0);
    set_id(5'd21, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("mrst_pre", 32'(ctl()), 32'h0000_0002);
    rstn = 1'b0;
    #1;
    chk("mrst_ctl", 32'(ctl()), 32'h0000_000C);
    chk("mrst_err", 32'(sb_if.sb_err), 32'd0);
    chk("mrst_perf", sb_if.stall_cycles, 32'd0);
    #2;
    rstn = 1'b1;
    tick();
    dep("mrst", 5'd21, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 0);

    // Completion to idle x9: sticky error until reset
    sb_if.cpl_valid = 1'b1; sb_if.cpl_rd = 5'd9; sb_if.cpl_file = 1'b0;
    tick();
    idle();
    #1;
    chk("cpl_err_set", 32'(sb_if.sb_err), 32'd1);
    repeat (3) tick();
    chk("cpl_err_sticky", 32'(sb_if.sb_err), 32'd1);
    rstn = 1'b0;
    #1;
    chk("cpl_err_clr", 32'(sb_if.sb_err), 32'd0);
    rstn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
